dmem_responder: RTL

- Responder (memory) end of the data-memory load/store interface that the processor datapath drives.
- Accepts one load/store request at a time through a valid/ready handshake.
- Applies a configurable number of wait states, then returns a response: load data (sign- or zero-extended) or a store acknowledgement, plus an alignment error flag.
- Intended to replace the combinational data memory when the multi-cycle core is built.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 41 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and
// the alignment rule that decides whether a request is rejected.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Size 2'b11 is never legal; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: store byte enables / replicated write word,
// and load extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rword_i >> {addr_i, 3'b000};
    assign half_sh = rword_i >> {addr_i[1], 4'b0000};

    always_comb begin
        be_o    = 4'b0000;
        wword_o = wdata_i;
        rdata_o = rword_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & byte_sh[7]}}, byte_sh[7:0]};
            end
            SZ_HALF: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & half_sh[15]}}, half_sh[15:0]};
            end
            SZ_WORD: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: one request at a time, WAIT_STATES cycles of wait,
// then a held response (load data or store ack plus alignment error).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);
    localparam int         WORDS   = 1 << (DM_ADDRESS - 2);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q, unsigned_q;
    logic [1:0]            size_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  req_ready_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic [DATA_W-1:0]     mem_q [0:WORDS-1];

    logic                  idle, enter_resp, err_d;
    logic                  write_d, unsigned_d;
    logic [1:0]            size_d;
    logic [DM_ADDRESS-1:0] addr_d;
    logic [DATA_W-1:0]     wdata_d, rword, wword, ld_val;
    logic [3:0]            be;

    // With zero wait states the accept edge is also the access edge, so the
    // live request is used instead of the latched copy.
    assign idle       = state_q == ST_IDLE;
    assign write_d    = idle ? req_write    : write_q;
    assign size_d     = idle ? req_size     : size_q;
    assign unsigned_d = idle ? req_unsigned : unsigned_q;
    assign addr_d     = idle ? req_addr     : addr_q;
    assign wdata_d    = idle ? req_wdata    : wdata_q;
    assign err_d      = misaligned(size_d, addr_d[1:0]);
    assign rword      = mem_q[addr_d[DM_ADDRESS-1:2]];

    assign enter_resp = (idle && req_valid && WAIT_STATES == 0) ||
                        (state_q == ST_WAIT && cnt_q == WS_LAST);

    dmem_lane_align u_align (
        .size_i     (size_d),
        .addr_i     (addr_d[1:0]),
        .unsigned_i (unsigned_d),
        .wdata_i    (wdata_d),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ld_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    write_q     <= req_write;
                    size_q      <= req_size;
                    unsigned_q  <= req_unsigned;
                    addr_q      <= req_addr;
                    wdata_q     <= req_wdata;
                    req_ready_q <= 1'b0;
                    cnt_q       <= 4'd0;
                    state_q     <= enter_resp ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (enter_resp) state_q <= ST_RESP;
                    else            cnt_q   <= cnt_q + 4'd1;
                end
                ST_RESP: if (rsp_ready) begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (enter_resp) begin
                cnt_q       <= 4'd0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_d;
                rsp_rdata_q <= (err_d || write_d) ? '0 : ld_val;
            end
        end
    end

    // Array is deliberately not reset; a store only lands on its RESP-entry edge.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && write_d && !err_d) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[addr_d[DM_ADDRESS-1:2]][8*b +: 8] <= wword[8*b +: 8];
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
